// File: rtl/ram2_pingpong_ctrl.sv
// ram2_pingpong_ctrl: sequences a simple dual-port RAM as two ping-pong frame banks.
// Optional macro RAM2_PINGPONG_STATS_EN adds the frame_cnt / drop_cnt statistics outputs.
module ram2_pingpong_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  frame_ready,
    input  logic                  rd_start,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    output logic                  busy,
    output logic                  overflow,
`ifdef RAM2_PINGPONG_STATS_EN
    output logic [15:0]           frame_cnt,
    output logic [15:0]           drop_cnt,
`endif
    input  logic                  clr_ovf
);
    // state | meaning
    // IDLE  | waiting for rd_start while a full bank is pending
    // READ  | issuing FRAME consecutive read addresses from rd_bank
    // DRAIN | waiting for the last tagged word to reach m_data
    typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;

    localparam int PTR_W = ADDR_WIDTH - 1;
    localparam logic [PTR_W-1:0] LAST_PTR = '1;

    rd_state_t        state;
    logic             wr_bank;
    logic             rd_bank;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_cnt;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             rd_bank_nxt;
    logic [RD_LATENCY:0] vld_pipe;
    logic [RD_LATENCY:0] last_pipe;
    logic             accept;
    logic             drop;
    logic             wr_done;
    logic             rd_done;

    assign accept  = s_valid && !full[wr_bank];
    assign drop    = s_valid && full[wr_bank];
    assign wr_done = accept && (wr_ptr == LAST_PTR);
    assign rd_done = (state == DRAIN) && vld_pipe[RD_LATENCY] && last_pipe[RD_LATENCY];

    // Writer and reader never touch the same bank, so set and clear are independent.
    always_comb begin
        full_nxt = full;
        if (wr_done)
            full_nxt[wr_bank] = 1'b1;
        if (rd_done)
            full_nxt[rd_bank] = 1'b0;
        rd_bank_nxt = rd_bank ^ rd_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            wr_ptr      <= '0;
            wr_bank     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            ram_wr_en <= accept;
            if (accept) begin
                ram_wr_addr <= {wr_bank, wr_ptr};
                ram_wr_data <= s_data;
                wr_ptr      <= wr_ptr + 1'b1;
                if (wr_ptr == LAST_PTR)
                    wr_bank <= ~wr_bank;
            end
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    // frame_ready follows the post-update bank state so a back-to-back start sees the next bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full        <= 2'b00;
            rd_bank     <= 1'b0;
            frame_ready <= 1'b0;
        end else begin
            full        <= full_nxt;
            rd_bank     <= rd_bank_nxt;
            frame_ready <= full_nxt[rd_bank_nxt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_cnt      <= '0;
            ram_rd_addr <= '0;
            busy        <= 1'b0;
            vld_pipe    <= '0;
            last_pipe   <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            m_data      <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[RD_LATENCY-1:0], state == READ};
            last_pipe <= {last_pipe[RD_LATENCY-1:0], (state == READ) && (rd_cnt == LAST_PTR)};
            m_valid   <= vld_pipe[RD_LATENCY];
            m_last    <= vld_pipe[RD_LATENCY] && last_pipe[RD_LATENCY];
            if (vld_pipe[RD_LATENCY])
                m_data <= ram_rd_data;
            case (state)
                IDLE: begin
                    if (rd_start && frame_ready) begin
                        state  <= READ;
                        rd_cnt <= '0;
                        busy   <= 1'b1;
                    end
                end
                READ: begin
                    ram_rd_addr <= {rd_bank, rd_cnt};
                    rd_cnt      <= rd_cnt + 1'b1;
                    if (rd_cnt == LAST_PTR)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (rd_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RAM2_PINGPONG_STATS_EN
    // A drop coinciding with clr_ovf is counted as the first drop after the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'h0000;
            drop_cnt  <= 16'h0000;
        end else begin
            if (rd_done)
                frame_cnt <= frame_cnt + 16'h0001;
            if (clr_ovf)
                drop_cnt <= {15'h0000, drop};
            else if (drop && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'h0001;
        end
    end
`else
    // Statistics disabled: no extra ports or registers.
`endif

endmodule

// File: tb/tb_ram2_pingpong_ctrl.sv
// tb_ram2_pingpong_ctrl: two controllers (RAM read latency 1 and 2) driven in lockstep,
// checked by a vector table, directed sequences and a frame-level reference model.
module tb_ram2_pingpong_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int FRAME = 8;

    logic rd_clk_tb = 1'b0;
    logic tb_rst;
    logic s_valid;
    logic rd_start;
    logic clr_ovf;
    logic [DW-1:0] s_data;

    logic [1:0] wen, frdy, mval, mlast, busy, ovf;
    logic [1:0][AW-1:0] waddr, raddr;
    logic [1:0][DW-1:0] wdata, rdata, mdata, rq1, rq2;
    logic [DW-1:0] mem [2][16];

    int checks = 0;
    int failures = 0;

    // reference model: per controller, count of complete frames, oldest slot, fill pointer
    int cyc;
    int cnt [2];
    int head [2];
    int wptr [2];
    int t0 [2];
    bit reading [2];
    bit movf [2];
    logic [DW-1:0] fd [2][2][FRAME];

    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic          co;
        logic          e_wen;
        logic [AW-1:0] e_waddr;
        logic          e_frdy;
        logic          e_ovf;
    } vec_t;
    vec_t vecs [21];

    always #5 rd_clk_tb = ~rd_clk_tb;

    ram2_pingpong_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_lat1 (
        .clk(rd_clk_tb), .rst(tb_rst), .s_data(s_data), .s_valid(s_valid),
        .ram_wr_en(wen[0]), .ram_wr_addr(waddr[0]), .ram_wr_data(wdata[0]),
        .ram_rd_addr(raddr[0]), .ram_rd_data(rdata[0]), .frame_ready(frdy[0]),
        .rd_start(rd_start), .m_data(mdata[0]), .m_valid(mval[0]), .m_last(mlast[0]),
        .busy(busy[0]), .overflow(ovf[0]), .clr_ovf(clr_ovf)
    );

    ram2_pingpong_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_lat2 (
        .clk(rd_clk_tb), .rst(tb_rst), .s_data(s_data), .s_valid(s_valid),
        .ram_wr_en(wen[1]), .ram_wr_addr(waddr[1]), .ram_wr_data(wdata[1]),
        .ram_rd_addr(raddr[1]), .ram_rd_data(rdata[1]), .frame_ready(frdy[1]),
        .rd_start(rd_start), .m_data(mdata[1]), .m_valid(mval[1]), .m_last(mlast[1]),
        .busy(busy[1]), .overflow(ovf[1]), .clr_ovf(clr_ovf)
    );

    // behavioural RAMs: latency 1 for u_lat1, 2 for u_lat2
    always @(posedge rd_clk_tb) begin
        for (int d = 0; d < 2; d++) begin
            if (wen[d])
                mem[d][waddr[d]] <= wdata[d];
            rq1[d] <= mem[d][raddr[d]];
            rq2[d] <= rq1[d];
        end
    end
    assign rdata[0] = rq1[0];
    assign rdata[1] = rq2[1];

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=0x%0h required=0x%0h", name, d, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0; head[d] = 0; wptr[d] = 0; t0[d] = 0;
            reading[d] = 1'b0; movf[d] = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input logic sv, input logic [DW-1:0] sd,
                              input logic rs, input logic co);
        int cnt0, ws, idx, lat;
        bit acc, drop, racc, ev, el;
        logic [DW-1:0] ed;
        lat  = d + 1;
        cnt0 = cnt[d];
        ws   = (head[d] + cnt0) % 2;
        acc  = sv && (cnt0 < 2);
        drop = sv && (cnt0 == 2);
        racc = !reading[d] && rs && (cnt0 > 0);
        ev = 1'b0; el = 1'b0; ed = '0; idx = 0;
        if (reading[d] && cyc >= t0[d] + 2 + lat) begin
            idx = cyc - (t0[d] + 2 + lat);
            ev  = 1'b1;
            el  = (idx == FRAME - 1);
            ed  = fd[d][head[d]][idx];
        end
        check("wr_en", d, wen[d], acc);
        if (acc) begin
            check("wr_addr", d, waddr[d], ws * FRAME + wptr[d]);
            check("wr_data", d, wdata[d], sd);
        end
        if (reading[d] && cyc >= t0[d] + 1 && cyc <= t0[d] + FRAME)
            check("rd_addr", d, raddr[d], head[d] * FRAME + cyc - t0[d] - 1);
        check("m_valid", d, mval[d], ev);
        check("m_last", d, mlast[d], el);
        if (ev)
            check("m_data", d, mdata[d], ed);
        if (acc) begin
            fd[d][ws][wptr[d]] = sd;
            wptr[d]++;
            if (wptr[d] == FRAME) begin
                wptr[d] = 0;
                cnt[d]++;
            end
        end
        if (el) begin
            cnt[d]--;
            head[d] = 1 - head[d];
            reading[d] = 1'b0;
        end
        if (racc) begin
            reading[d] = 1'b1;
            t0[d] = cyc;
        end
        if (drop)
            movf[d] = 1'b1;
        else if (co)
            movf[d] = 1'b0;
        check("frame_ready", d, frdy[d], cnt[d] > 0);
        check("busy", d, busy[d], reading[d]);
        check("overflow", d, ovf[d], movf[d]);
    endtask

    task automatic tick(input logic sv, input logic [DW-1:0] sd, input logic rs, input logic co);
        s_valid = sv; s_data = sd; rd_start = rs; clr_ovf = co;
        @(posedge rd_clk_tb);
        #1;
        if (!tb_rst) begin
            cyc++;
            model_step(0, sv, sd, rs, co);
            model_step(1, sv, sd, rs, co);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_wr_en"}, d, wen[d], 0);
            check({tag, "_wr_addr"}, d, waddr[d], 0);
            check({tag, "_wr_data"}, d, wdata[d], 0);
            check({tag, "_rd_addr"}, d, raddr[d], 0);
            check({tag, "_frame_ready"}, d, frdy[d], 0);
            check({tag, "_m_data"}, d, mdata[d], 0);
            check({tag, "_m_valid"}, d, mval[d], 0);
            check({tag, "_m_last"}, d, mlast[d], 0);
            check({tag, "_busy"}, d, busy[d], 0);
            check({tag, "_overflow"}, d, ovf[d], 0);
        end
    endtask

    task automatic fill(input logic [DW-1:0] base);
        for (int i = 0; i < FRAME; i++)
            tick(1'b1, base + DW'(i), 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
    endtask

    // rd_start, then collect one frame from both controllers; optionally re-request mid-read
    task automatic read_frame(input logic [DW-1:0] base, input bit poke);
        int first [2];
        int nb [2];
        bit got_last [2];
        int t;
        for (int d = 0; d < 2; d++) begin
            first[d] = -1; nb[d] = 0; got_last[d] = 1'b0;
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        t = cyc;
        for (int k = 0; k < 40 && !(got_last[0] && got_last[1]); k++) begin
            tick(1'b0, '0, poke && (k == 4), 1'b0);
            for (int d = 0; d < 2; d++) begin
                if (mval[d] && !got_last[d]) begin
                    if (first[d] < 0)
                        first[d] = cyc - t;
                    check("beat_data", d, mdata[d], base + DW'(nb[d]));
                    nb[d]++;
                    if (mlast[d])
                        got_last[d] = 1'b1;
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            check("first_beat_latency", d, first[d], d + 3);
            check("beat_count", d, nb[d], FRAME);
            check("last_seen", d, got_last[d], 1);
        end
    endtask

    initial begin
        int nb0;
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, DW'(i + 1), 1'b0, 1'b1, AW'(i), (i == 7), 1'b0};
        vecs[8] = '{1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0};
        for (int j = 0; j < 8; j++)
            vecs[9 + j] = '{1'b1, DW'(32'h11 + j), 1'b0, 1'b1, AW'(8 + j), 1'b1, 1'b0};
        for (int j = 0; j < 3; j++)
            vecs[17 + j] = '{1'b1, 32'hAA, 1'b0, 1'b0, '0, 1'b1, 1'b1};
        vecs[20] = '{1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0};

        tb_rst = 1'b1; s_valid = 1'b0; s_data = '0; rd_start = 1'b0; clr_ovf = 1'b0;
        model_reset();
        repeat (3) @(posedge rd_clk_tb);
        #1;
        check_zero("reset");
        @(negedge rd_clk_tb);
        tb_rst = 1'b0;

        // fill both banks, overflow, clear
        for (int i = 0; i < 21; i++) begin
            tick(vecs[i].sv, vecs[i].sd, 1'b0, vecs[i].co);
            for (int d = 0; d < 2; d++) begin
                check("tbl_wr_en", d, wen[d], vecs[i].e_wen);
                if (vecs[i].e_wen)
                    check("tbl_wr_addr", d, waddr[d], vecs[i].e_waddr);
                check("tbl_frame_ready", d, frdy[d], vecs[i].e_frdy);
                check("tbl_overflow", d, ovf[d], vecs[i].e_ovf);
            end
        end

        // ping-pong order, ignored mid-read request, back-to-back start
        read_frame(32'h1, 1'b1);
        for (int d = 0; d < 2; d++) check("bank1_pending", d, frdy[d], 1);
        read_frame(32'h11, 1'b0);
        for (int d = 0; d < 2; d++) begin
            check("drained_frame_ready", d, frdy[d], 0);
            check("drained_busy", d, busy[d], 0);
        end

        // rd_start with nothing to read
        tick(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, '0, 1'b0, 1'b0);
            for (int d = 0; d < 2; d++) begin
                check("ignored_busy", d, busy[d], 0);
                check("ignored_m_valid", d, mval[d], 0);
            end
        end

        // reset on the 4th beat of a read
        fill(32'h21);
        tick(1'b0, '0, 1'b1, 1'b0);
        nb0 = 0;
        for (int k = 0; k < 20 && nb0 < 4; k++) begin
            tick(1'b0, '0, 1'b0, 1'b0);
            if (mval[0]) nb0++;
        end
        check("reach_beat4", 0, nb0, 4);
        tb_rst = 1'b1;
        #1;
        check_zero("midrst");
        model_reset();
        repeat (2) @(posedge rd_clk_tb);
        @(negedge rd_clk_tb);
        tb_rst = 1'b0;
        fill(32'h31);
        read_frame(32'h31, 1'b0);

        // random traffic against the model
        for (int k = 0; k < 600; k++)
            tick($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram2_pingpong_ctrl.md
Name: ram2_pingpong_ctrl

Overview:
- Sequences the 1024x32 simple dual-port sample RAM (ram2) as two ping-pong frame banks.
- Audio samples stream into one half while the FFT/display path reads out the other completed half.
- Sits between the audio capture path and the FFT input. It owns all RAM address and enable generation.
- Single clock domain: both RAM ports are driven from clk.

Parameters:
- ADDR_WIDTH, 10: RAM address width. Bank select is the MSB. Frame length FRAME = 2**(ADDR_WIDTH-1).
- DATA_WIDTH, 32: sample/RAM data width.
- RD_LATENCY, 1: RAM read latency in cycles. 1 when the RAM OUT_REG=0, 2 when OUT_REG=1.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  DATA_WIDTH  incoming audio sample.
- s_valid  in  1  sample strobe. No backpressure is provided.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  DATA_WIDTH  RAM read data.
- frame_ready  out  1  at least one bank is full and unread.
- rd_start  in  1  request to read out the oldest full bank.
- m_data  out  DATA_WIDTH  frame output data.
- m_valid  out  1  m_data qualifier.
- m_last  out  1  asserted with the final word of a frame.
- busy  out  1  read FSM is not IDLE.
- overflow  out  1  sticky flag: a sample was dropped.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Reset: all outputs are 0. Internal state on reset:
  - wr_bank=0, wr_ptr=0, rd_bank=0.
  - full[1:0]=0.
  - Read FSM in IDLE, valid pipeline flushed.
- Reset mid-frame discards all buffered data; no partial m_valid follows.
- Write side:
  - A sample is accepted when s_valid=1 and full[wr_bank]=0.
  - In the next cycle: ram_wr_en=1, ram_wr_addr={wr_bank,wr_ptr}, ram_wr_data=s_data.
  - ram_wr_en is 0 in every cycle that does not follow an accepted sample.
  - After accepting the sample at wr_ptr==FRAME-1: set full[wr_bank], toggle wr_bank, wrap wr_ptr to 0.
- Overflow:
  - s_valid=1 while full[wr_bank]=1 drops the sample, issues no write, and sets overflow.
  - overflow stays set until clr_ovf=1.
  - If clr_ovf and a drop occur in the same cycle, the set wins.
- frame_ready = full[rd_bank], registered.
- Read FSM, states IDLE -> READ -> DRAIN -> IDLE:
  - IDLE: rd_start && frame_ready goes to READ and starts the address counter at 0. rd_start while !frame_ready is ignored.
  - READ: drives ram_rd_addr={rd_bank,cnt} on each of FRAME consecutive cycles. After cnt==FRAME-1, go to DRAIN.
  - DRAIN: wait for the valid pipeline to empty. On the cycle m_last is driven: clear full[rd_bank], toggle rd_bank, go to IDLE.
  - rd_start outside IDLE is ignored.
- Read latency:
  - A valid tag is delayed RD_LATENCY cycles, then registered with ram_rd_data into m_data/m_valid.
  - With rd_start sampled at edge t, the first m_valid is at edge t+2+RD_LATENCY.
  - Exactly FRAME consecutive m_valid beats follow, with m_last on the FRAME-th.
- Simultaneous events:
  - The writer setting full on one bank and the reader clearing the other in the same cycle: both take effect.
  - The writer never targets a full bank, so set and clear on the same bank cannot collide.
  - A back-to-back rd_start in the cycle after returning to IDLE is honoured.
- Bank order: banks are read strictly in fill order, because rd_bank and wr_bank both alternate from 0.

Optional Feature:
- Macro: RAM2_PINGPONG_STATS_EN.
- When defined, two extra outputs are added:
  - frame_cnt [15:0]: increments on every m_last and wraps at 0xFFFF.
  - drop_cnt [15:0]: increments on every dropped sample and saturates at 0xFFFF.
  - Both reset to 0. clr_ovf also zeroes drop_cnt.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Fill a frame: ADDR_WIDTH=4 (FRAME=8), feed 8 samples 0x1..0x8 -> ram_wr_addr 0..7 each one cycle after s_valid; frame_ready=1 after the 8th; wr_bank=1.
- Read latency: after the fill, pulse rd_start at edge t, RD_LATENCY=1 and 2 -> m_valid first at t+3 / t+4; m_data 0x1..0x8 over 8 consecutive beats; m_last with 0x8; then frame_ready=0, busy=0.
- Ping-pong order: fill bank0 (0x1..0x8) and bank1 (0x11..0x18), then issue two rd_start -> outputs 0x1..0x8 then 0x11..0x18; ram_rd_addr 0..7 then 8..15.
- Overflow: fill both banks, send 3 more samples -> no ram_wr_en, overflow=1 (drop_cnt=3 with the macro); clr_ovf -> overflow=0.
- Ignored request: rd_start with frame_ready=0 -> busy stays 0, no m_valid; a second rd_start mid-READ -> still exactly 8 beats.
- Reset mid-read: assert rst on the 4th m_valid beat -> all outputs 0 at once, frame_ready=0; a fresh fill then reads correctly from bank0.
